// File: rtl/side_road_detector_if.sv
// ---------------------------------------------------------------------------
// side_road_detector_if
// Signal bundle between the loop-detector conditioner and its neighbours.
//   det_raw   : raw asynchronous loop level (1 = vehicle over loop)
//   sg        : side-road green indication from the controller FSM
//   c         : registered car-request level to the controller FSM
//   det_filt  : debounced detector level
//   arrive    : one-cycle pulse per debounced arrival
//   car_count : saturating arrival count
// master drives det_raw/sg (controller side), slave is the detector block.
// ---------------------------------------------------------------------------
interface side_road_detector_if #(
    parameter int CNT_W = 8
);
    logic             det_raw;
    logic             sg;
    logic             c;
    logic             det_filt;
    logic             arrive;
    logic [CNT_W-1:0] car_count;

    modport master (
        output det_raw, sg,
        input  c, det_filt, arrive, car_count
    );

    modport slave (
        input  det_raw, sg,
        output c, det_filt, arrive, car_count
    );
endinterface

// File: rtl/side_road_detector.sv
// ---------------------------------------------------------------------------
// side_road_detector
// Conditions the side-road loop detector and produces the car-request level
// `c` for the traffic-light controller.
//   clk    : system clock, all state on rising edge
//   reset  : synchronous, active-high
//   bus    : side_road_detector_if.slave (det_raw, sg in; c, det_filt,
//            arrive, car_count out)
// Path: 2-flop synchronizer -> debounce -> arrival pulse/counter, and a
// request FSM that latches a request until served, with gap-out on green.
// ---------------------------------------------------------------------------
module side_road_detector #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    side_road_detector_if.slave   bus
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SERVE, GAP} state_t;

    logic             r_s1, r_s2;
    logic [DW-1:0]    r_deb;
    logic             r_filt, r_filt_d;
    logic             r_arrive;
    logic [CNT_W-1:0] r_count;
    state_t           r_state, w_state_nxt;
    logic [GW-1:0]    r_gap, w_gap_nxt;
    logic             r_c;

    // Synchronizer, debounce, arrival pulse and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_deb    <= '0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_arrive <= 1'b0;
            r_count  <= '0;
        end else begin
            r_s1     <= bus.det_raw;
            r_s2     <= r_s1;
            // Counter only runs while the synchronized level disagrees with
            // the filtered one; any agreeing sample restarts the count.
            if (r_s2 != r_filt) begin
                if (r_deb == DW'(DEB_CYCLES - 1)) begin
                    r_filt <= r_s2;
                    r_deb  <= '0;
                end else begin
                    r_deb  <= r_deb + 1'b1;
                end
            end else begin
                r_deb <= '0;
            end
            r_filt_d <= r_filt;
            r_arrive <= r_filt & ~r_filt_d;
            if (r_arrive && (r_count != {CNT_W{1'b1}}))
                r_count <= r_count + 1'b1;
        end
    end

    // Request FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gap   <= '0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_c     <= (w_state_nxt != IDLE);
        end
    end

    // Request FSM: next state. sg changes outrank det_filt, which outranks
    // the gap timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (r_filt)
                    w_state_nxt = bus.sg ? SERVE : WAIT;
            end
            WAIT: begin
                if (bus.sg)
                    w_state_nxt = r_filt ? SERVE : GAP;
            end
            SERVE: begin
                if (!bus.sg)
                    w_state_nxt = r_filt ? WAIT : IDLE;
                else if (!r_filt)
                    w_state_nxt = GAP;
            end
            GAP: begin
                if (!bus.sg)
                    w_state_nxt = r_filt ? WAIT : IDLE;
                else if (r_filt)
                    w_state_nxt = SERVE;
                else if (r_gap == GW'(GAP_CYCLES - 1))
                    w_state_nxt = IDLE;
                else
                    w_gap_nxt = r_gap + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.c         = r_c;
    assign bus.det_filt  = r_filt;
    assign bus.arrive    = r_arrive;
    assign bus.car_count = r_count;
endmodule

// File: tb/tb_side_road_detector.sv
// ---------------------------------------------------------------------------
// tb_side_road_detector
// Random det_raw/sg stimulus with occasional resets. A behavioural model
// pushes the expected outputs for every clock edge into a queue; a separate
// monitor pops one entry per edge and compares all four outputs.
// ---------------------------------------------------------------------------
module tb_side_road_detector;
    localparam int DEB   = 4;
    localparam int GAPC  = 3;
    localparam int CW    = 2;
    localparam int NCYC  = 4000;

    logic clk = 1'b0;
    logic reset;

    side_road_detector_if #(.CNT_W(CW)) bus ();

    side_road_detector #(
        .DEB_CYCLES(DEB), .GAP_CYCLES(GAPC), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          c;
        logic          filt;
        logic          arrive;
        logic [CW-1:0] count;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // ---------------- reference model ----------------
    // Debounce as a window of synchronized samples: the filtered level flips
    // once DEB consecutive samples have all disagreed with it.
    logic m_s1, m_s2, m_filt, m_rose, m_arrive;
    int   m_count;
    bit   win[$];
    // Request: req = c; served = side road has had green for this request;
    // gap_age = cycles spent gapping (-1 when not gapping).
    bit   m_req, m_served;
    int   m_gap;

    always @(posedge clk) begin
        exp_t e;
        logic f, s, s2_old;
        bit   all_diff;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_rose = 0; m_arrive = 0;
            m_count = 0; win.delete();
            m_req = 0; m_served = 0; m_gap = -1;
        end else begin
            f      = m_filt;
            s      = bus.sg;
            s2_old = m_s2;
            // counter sees the pulse from the previous edge
            if (m_arrive && m_count < (1 << CW) - 1) m_count++;
            m_arrive = m_rose;
            m_rose   = 0;
            // request logic on pre-edge det_filt and sg
            if (!m_req) begin
                if (f) begin m_req = 1; m_served = s; m_gap = -1; end
            end else if (!m_served) begin
                if (s) begin m_served = 1; m_gap = f ? -1 : 0; end
            end else begin
                if (!s)             begin m_req = f; m_served = 0; m_gap = -1; end
                else if (f)         m_gap = -1;
                else if (m_gap < 0) m_gap = 0;
                else if (m_gap == GAPC - 1) begin m_req = 0; m_served = 0; m_gap = -1; end
                else                m_gap++;
            end
            // debounce window
            win.push_back(s2_old);
            if (win.size() > DEB) void'(win.pop_front());
            all_diff = (win.size() == DEB);
            foreach (win[i]) if (win[i] == f) all_diff = 0;
            if (all_diff) begin
                m_filt = ~f;
                m_rose = ~f;
                win.delete();
            end
            m_s2 = m_s1;
            m_s1 = bus.det_raw;
        end
        e.c = m_req; e.filt = m_filt; e.arrive = m_arrive; e.count = CW'(m_count);
        q.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = q.pop_front();
            chk("c",         int'(bus.c),         int'(e.c));
            chk("det_filt",  int'(bus.det_filt),  int'(e.filt));
            chk("arrive",    int'(bus.arrive),    int'(e.arrive));
            chk("car_count", int'(bus.car_count), int'(e.count));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int raw_hold, sg_hold;
        reset       = 1'b1;
        bus.det_raw = 1'b1;
        bus.sg      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // car held from reset release: det_filt then c rise
        repeat (10) @(negedge clk);
        // short glitch must be rejected
        bus.det_raw = 1'b0;
        repeat (10) @(negedge clk);
        bus.det_raw = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        bus.det_raw = 1'b0;
        repeat (10) @(negedge clk);
        raw_hold = 0;
        sg_hold  = 0;
        for (int i = 0; i < NCYC; i++) begin
            if (raw_hold == 0) begin
                bus.det_raw = ~bus.det_raw;
                raw_hold    = $urandom_range(1, 12);
            end
            if (sg_hold == 0) begin
                bus.sg  = ~bus.sg;
                sg_hold = $urandom_range(1, 20);
            end
            raw_hold--;
            sg_hold--;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        done = 1;
    end

    initial begin
        wait (done);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
